// File: rtl/rpn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rpn_sequencer
//  Purpose  : Reverse-Polish token sequencer driving a 16-entry byte stack.
//             Accepts operand/operator tokens over valid/ready, sequences all
//             stack push/pop strobes, runs the 8-bit ALU and emits results
//             and error codes.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             tok_valid/tok_ready   - token handshake
//             tok_is_op, tok_data   - token kind and operand / opcode[2:0]
//             stk_push, stk_pop     - registered stack strobes
//             stk_data_in           - byte pushed with stk_push
//             stk_data_out          - stack popped data (STK_LAT after strobe)
//             stk_error             - stack over/underflow flag
//             res_valid, res_data   - one-cycle result pulse, held data
//             err, err_code         - one-cycle error pulse with code
//  Revision : 1.0 - initial release
// ============================================================================
module rpn_sequencer #(
    parameter int STK_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic       tok_is_op,
    input  logic [7:0] tok_data,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_data_in,
    input  logic [7:0] stk_data_out,
    input  logic       stk_error,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       err,
    output logic [1:0] err_code
);

    // WAIT lasts STK_LAT-1 cycles; the counter is loaded with STK_LAT-2.
    localparam int       c_CNT_W     = (STK_LAT > 2) ? $clog2(STK_LAT - 1) : 1;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_OUT  = 3'b100;

    localparam logic [1:0] c_ERR_UNDER = 2'b01;
    localparam logic [1:0] c_ERR_OVER  = 2'b10;
    localparam logic [1:0] c_ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STRB  = 2'd1,
        S_WAIT  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_POP_A = 2'd0,
        PH_POP_B = 2'd1,
        PH_PUSH  = 2'd2,
        PH_EMIT  = 2'd3
    } phase_t;

    state_t             r_state, w_state_nx;
    phase_t             r_phase, w_phase_nx;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic [2:0]         r_op,    w_op_nx;
    logic [7:0]         r_a,     w_a_nx;
    logic               r_push,  w_push_nx;
    logic               r_pop,   w_pop_nx;
    logic [7:0]         r_data_in,   w_data_in_nx;
    logic               r_res_valid, w_res_valid_nx;
    logic [7:0]         r_res_data,  w_res_data_nx;
    logic               r_err,       w_err_nx;
    logic [1:0]         r_err_code,  w_err_code_nx;

    logic               w_accept;
    logic [7:0]         w_alu;

    // Ready drops while a result or error pulse is on the bus so that a
    // completion and a new acceptance never share a cycle.
    assign tok_ready = (r_state == S_IDLE) && !r_res_valid && !r_err && !reset;
    assign w_accept  = tok_valid && tok_ready;

    // B is the second popped operand and is consumed straight from the
    // stack read port in the POP_B check cycle; A was captured earlier.
    always_comb begin
        w_alu = 8'h00;
        case (r_op)
            c_OP_ADD: w_alu = stk_data_out + r_a;
            c_OP_SUB: w_alu = stk_data_out - r_a;
            c_OP_AND: w_alu = stk_data_out & r_a;
            c_OP_XOR: w_alu = stk_data_out ^ r_a;
            default:  w_alu = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_cnt_nx       = r_cnt;
        w_op_nx        = r_op;
        w_a_nx         = r_a;
        w_push_nx      = 1'b0;
        w_pop_nx       = 1'b0;
        w_data_in_nx   = r_data_in;
        w_res_valid_nx = 1'b0;
        w_res_data_nx  = r_res_data;
        w_err_nx       = 1'b0;
        w_err_code_nx  = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!tok_is_op) begin
                        w_phase_nx   = PH_PUSH;
                        w_push_nx    = 1'b1;
                        w_data_in_nx = tok_data;
                        w_state_nx   = S_STRB;
                    end else if (tok_data[2:0] > c_OP_OUT) begin
                        // Illegal opcode: consumed without touching the stack.
                        w_err_nx      = 1'b1;
                        w_err_code_nx = c_ERR_ILL;
                    end else begin
                        w_op_nx    = tok_data[2:0];
                        w_phase_nx = PH_POP_A;
                        w_pop_nx   = 1'b1;
                        w_state_nx = S_STRB;
                    end
                end
            end

            S_STRB: begin
                if (STK_LAT == 1) begin
                    w_state_nx = S_CHECK;
                end else begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = c_CNT_W'(STK_LAT - 2);
                end
            end

            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_CHECK;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end

            S_CHECK: begin
                w_state_nx = S_IDLE;
                case (r_phase)
                    PH_PUSH: begin
                        if (stk_error) begin
                            w_err_nx      = 1'b1;
                            w_err_code_nx = c_ERR_OVER;
                        end
                    end
                    PH_POP_A: begin
                        if (stk_error) begin
                            w_err_nx      = 1'b1;
                            w_err_code_nx = c_ERR_UNDER;
                        end else if (r_op == c_OP_OUT) begin
                            w_a_nx         = stk_data_out;
                            w_res_valid_nx = 1'b1;
                            w_res_data_nx  = stk_data_out;
                            w_phase_nx     = PH_EMIT;
                        end else begin
                            w_a_nx     = stk_data_out;
                            w_phase_nx = PH_POP_B;
                            w_pop_nx   = 1'b1;
                            w_state_nx = S_STRB;
                        end
                    end
                    PH_POP_B: begin
                        // Underflow here drops A: nothing is pushed back.
                        if (stk_error) begin
                            w_err_nx      = 1'b1;
                            w_err_code_nx = c_ERR_UNDER;
                        end else begin
                            w_data_in_nx = w_alu;
                            w_push_nx    = 1'b1;
                            w_phase_nx   = PH_PUSH;
                            w_state_nx   = S_STRB;
                        end
                    end
                    default: begin
                        w_state_nx = S_IDLE;
                    end
                endcase
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_POP_A;
            r_cnt       <= '0;
            r_op        <= 3'b000;
            r_a         <= 8'h00;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_data_in   <= 8'h00;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_cnt       <= w_cnt_nx;
            r_op        <= w_op_nx;
            r_a         <= w_a_nx;
            r_push      <= w_push_nx;
            r_pop       <= w_pop_nx;
            r_data_in   <= w_data_in_nx;
            r_res_valid <= w_res_valid_nx;
            r_res_data  <= w_res_data_nx;
            r_err       <= w_err_nx;
            r_err_code  <= w_err_code_nx;
        end
    end

    assign stk_push    = r_push;
    assign stk_pop     = r_pop;
    assign stk_data_in = r_data_in;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rpn_sequencer
//  Purpose  : Self-checking bench for rpn_sequencer with a behavioural
//             16-entry stack of latency STK_LAT. Table-driven token vectors
//             plus hand-written held-valid and mid-operation reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rpn_sequencer;

    localparam int c_STK_LAT = 2;
    localparam int c_NONE    = 0;
    localparam int c_RES     = 1;
    localparam int c_ERR     = 2;
    localparam logic [15:0] c_M1   = 16'h0002;
    localparam logic [15:0] c_M14  = 16'h0012;
    localparam logic [15:0] c_M7   = 16'h0080;

    logic       clk = 1'b0;
    logic       reset;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [7:0] tok_data;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic       stk_error;
    logic       res_valid;
    logic [7:0] res_data;
    logic       err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    always #5 clk = ~clk;

    rpn_sequencer #(.STK_LAT(c_STK_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_error    (stk_error),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err          (err),
        .err_code     (err_code)
    );

    // ---------------- behavioural stack, latency 2 ----------------
    logic [7:0] mem [16];
    int         sp;
    logic [7:0] d1, d2;
    logic       e1, e2;

    always @(posedge clk) begin
        if (reset) begin
            sp <= 0;
            d1 <= 8'h00; d2 <= 8'h00;
            e1 <= 1'b0;  e2 <= 1'b0;
        end else begin
            if (stk_push) begin
                if (sp == 16) e1 <= 1'b1;
                else begin
                    mem[sp] <= stk_data_in;
                    sp      <= sp + 1;
                    e1      <= 1'b0;
                end
            end else if (stk_pop) begin
                if (sp == 0) e1 <= 1'b1;
                else begin
                    d1 <= mem[sp-1];
                    sp <= sp - 1;
                    e1 <= 1'b0;
                end
            end
            d2 <= d1;
            e2 <= e1;
        end
    end
    assign stk_data_out = d2;
    assign stk_error    = e2;

    always @(posedge clk) begin
        if (!reset && tok_valid && tok_ready) n_acc <= n_acc + 1;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_op;
        logic [7:0]  data;
        int          exp_kind;
        logic [7:0]  exp_val;
        int          exp_ev;
        int          exp_rdy;
        logic [15:0] exp_pop;
        logic [15:0] exp_push;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic is_op, input logic [7:0] d, input int k,
                       input logic [7:0] v, input int ev, input int rdy,
                       input logic [15:0] pm, input logic [15:0] qm);
        vec_t t;
        t.is_op = is_op; t.data = d; t.exp_kind = k; t.exp_val = v;
        t.exp_ev = ev; t.exp_rdy = rdy; t.exp_pop = pm; t.exp_push = qm;
        vecs.push_back(t);
    endtask

    task automatic add_push(input logic [7:0] d);     add(1'b0, d, c_NONE, 8'h00, 0, 4, 16'h0, c_M1); endtask
    task automatic add_push_ovf(input logic [7:0] d); add(1'b0, d, c_ERR, 8'h02, 4, 5, 16'h0, c_M1); endtask
    task automatic add_bin(input logic [7:0] op);     add(1'b1, op, c_NONE, 8'h00, 0, 10, c_M14, c_M7); endtask
    task automatic add_bin_ufa(input logic [7:0] op); add(1'b1, op, c_ERR, 8'h01, 4, 5, c_M1, 16'h0); endtask
    task automatic add_bin_ufb(input logic [7:0] op); add(1'b1, op, c_ERR, 8'h01, 7, 8, c_M14, 16'h0); endtask
    task automatic add_out_d(input logic [7:0] op, input logic [7:0] v);
        add(1'b1, op, c_RES, v, 4, 5, c_M1, 16'h0);
    endtask
    task automatic add_out(input logic [7:0] v);      add_out_d(8'h04, v); endtask
    task automatic add_out_uf();                      add(1'b1, 8'h04, c_ERR, 8'h01, 4, 5, c_M1, 16'h0); endtask
    task automatic add_ill(input logic [7:0] op);     add(1'b1, op, c_ERR, 8'h03, 1, 2, 16'h0, 16'h0); endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; cycle numbers follow the acceptance edge (cycle 0).
    task automatic send_token(input logic is_op, input logic [7:0] d,
                              output int kind, output logic [7:0] val,
                              output int ev, output int rdy,
                              output logic [15:0] popm, output logic [15:0] pushm,
                              output int viol);
        int   w;
        logic prev;
        kind = c_NONE; val = 8'h00; ev = 0; rdy = -1;
        popm = 16'h0; pushm = 16'h0; viol = 0; prev = 1'b0;
        w = 0;
        while (!tok_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!tok_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_wait: tok_ready=%0b, expected 1 within 50 cycles", tok_ready);
            return;
        end
        tok_is_op = is_op;
        tok_data  = d;
        tok_valid = 1'b1;
        @(negedge clk);
        tok_valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c < 16) begin
                popm[c[3:0]]  = stk_pop;
                pushm[c[3:0]] = stk_push;
            end
            if ((stk_push && stk_pop) || ((stk_push || stk_pop) && prev)) viol++;
            prev = stk_push || stk_pop;
            if (kind == c_NONE && res_valid) begin kind = c_RES; val = res_data; ev = c; end
            if (kind == c_NONE && err) begin kind = c_ERR; val = {6'b0, err_code}; ev = c; end
            if (tok_ready) begin rdy = c; break; end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int kind, ev, rdy, viol;
        logic [7:0]  val;
        logic [15:0] pm, qm;
        send_token(v.is_op, v.data, kind, val, ev, rdy, pm, qm, viol);
        n_checks++;
        if (kind != v.exp_kind || val !== v.exp_val || ev != v.exp_ev ||
            rdy != v.exp_rdy || pm !== v.exp_pop || qm !== v.exp_push) begin
            n_errors++;
            $display("FAIL vec%0d (op=%0b data=%02h): kind=%0d val=%02h ev=%0d rdy=%0d pop=%04h push=%04h, expected kind=%0d val=%02h ev=%0d rdy=%0d pop=%04h push=%04h",
                     idx, v.is_op, v.data, kind, val, ev, rdy, pm, qm,
                     v.exp_kind, v.exp_val, v.exp_ev, v.exp_rdy, v.exp_pop, v.exp_push);
        end
        chk("strobe_rules", viol, 0);
    endtask

    initial begin : main
        int   acc0;
        int   pulses;
        vec_t t;

        reset = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'h00;

        // Vector table: outcome kind/value, event cycle, ready cycle, strobe masks.
        add_push(8'h03); add_push(8'h05); add_bin(8'h00); add_out(8'h08); add_out_uf();
        add_push(8'h0A); add_push(8'h03); add_bin(8'h01); add_out(8'h07);
        add_push(8'h03); add_push(8'h05); add_bin(8'h01); add_out(8'hFE);
        add_push(8'hFA); add_push(8'h0A); add_bin(8'h00); add_out(8'h04);
        add_push(8'hF0); add_push(8'h3C); add_bin(8'h02); add_out(8'h30);
        add_push(8'hF0); add_push(8'h3C); add_bin(8'h03); add_out(8'hCC);
        add_push(8'h01); add_push(8'h02); add_bin(8'h08); add_out(8'h03);
        add_out_uf();
        add_push(8'h01); add_bin_ufb(8'h00); add_out_uf();
        add_bin_ufa(8'h01);
        add_ill(8'h07); add_ill(8'hFF); add_ill(8'h05); add_ill(8'h06);
        add_push(8'h42); add_out_d(8'hF4, 8'h42);
        for (int i = 0; i < 16; i++) add_push(8'(i * 17 + 1));
        add_push_ovf(8'hEE);
        for (int i = 15; i >= 0; i--) add_out(8'(i * 17 + 1));
        add_out_uf();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tok_ready", tok_ready, 0);
        chk("rst_stk_push", stk_push, 0);
        chk("rst_stk_pop", stk_pop, 0);
        chk("rst_stk_data_in", stk_data_in, 8'h00);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", tok_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // tok_valid held high: one transfer per ready window (edges 0, 4, 8).
        acc0      = n_acc;
        tok_is_op = 1'b0;
        tok_data  = 8'h50;
        tok_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tok_data = 8'h50 + 8'(n_acc - acc0);
        end
        tok_valid = 1'b0;
        chk("held_valid_transfers", n_acc - acc0, 3);
        add_out(8'h52); add_out(8'h51); add_out(8'h50); add_out_uf();
        for (int i = vecs.size() - 4; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset during the POP_B wait of an ADD.
        add_push(8'h01); add_push(8'h02);
        for (int i = vecs.size() - 2; i < vecs.size(); i++) run_vec(vecs[i], i);
        tok_is_op = 1'b1;
        tok_data  = 8'h00;
        tok_valid = 1'b1;
        @(negedge clk);                 // cycle 1
        tok_valid = 1'b0;
        repeat (3) @(negedge clk);      // cycle 4
        chk("rst_seq_popb_strobe", stk_pop, 1);
        @(negedge clk);                 // cycle 5, WAIT
        reset = 1'b1;
        @(negedge clk);                 // cycle 6
        chk("rst_seq_push_low", stk_push, 0);
        chk("rst_seq_pop_low", stk_pop, 0);
        chk("rst_seq_ready_low", tok_ready, 0);
        reset  = 1'b0;
        pulses = 0;
        @(negedge clk);                 // cycle 7
        chk("rst_seq_ready_high", tok_ready, 1);
        chk("rst_seq_no_push", stk_push, 0);
        for (int c = 0; c < 8; c++) begin
            if (err || res_valid || stk_push || stk_pop) pulses++;
            @(negedge clk);
        end
        chk("rst_seq_no_pulses", pulses, 0);
        add_out_uf();
        t = vecs[vecs.size() - 1];
        run_vec(t, vecs.size() - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rpn_sequencer.md
# rpn_sequencer

Reverse-Polish token sequencer sitting directly upstream of the 16-entry byte stack: it accepts operand and operator tokens over a valid/ready handshake, drives the stack's push/pop/data strobes, reads back popped data and the stack error flag, performs 8-bit ALU operations, and emits results. It owns all stack sequencing, so the stack never sees simultaneous push and pop or back-to-back strobes.

## Interface
- `STK_LAT`, default 2: cycles from a stack strobe cycle to the cycle in which the stack's `data_out`/`error` reflect that operation.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; shared with the stack.
- `tok_valid` in 1: token present.
- `tok_ready` out 1: sequencer can accept a token; a token transfers on an edge where valid and ready are both high.
- `tok_is_op` in 1: 1 = operator token, 0 = operand token.
- `tok_data` in 8: operand value, or opcode in [2:0] (upper bits ignored).
- `stk_push` out 1: stack push strobe, registered.
- `stk_pop` out 1: stack pop strobe, registered.
- `stk_data_in` out 8: byte to push, registered, valid while `stk_push` is high.
- `stk_data_out` in 8: stack popped data.
- `stk_error` in 1: stack over/underflow flag.
- `res_valid` out 1: one-cycle result pulse.
- `res_data` out 8: result byte, valid with `res_valid`, holds last value otherwise.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: 01 underflow, 10 overflow, 11 illegal opcode; valid with `err`, 00 otherwise.

## Operation
- Opcodes: 000 ADD (B+A), 001 SUB (B−A), 010 AND, 011 XOR, 100 OUT (pop and emit); 101–111 illegal. A = first popped (top), B = second popped.
- Arithmetic modulo 256; no carry or borrow output.
- States: IDLE, STRB, WAIT (counter), CHECK, plus a 2-bit phase register (POP_A, POP_B, PUSH, EMIT) selecting what the stack access does.
- A stack access = STRB (one strobe cycle) + WAIT (`STK_LAT`−1 cycles) + CHECK (sample `stk_data_out`/`stk_error`). With `STK_LAT`=2: 3 cycles per access.
- Operand token: phase PUSH, `stk_data_in`=tok_data. CHECK: `stk_error` → err, code 10; then IDLE.
- Operator token, binary: POP_A → capture A; POP_B → capture B; compute; PUSH result; CHECK → IDLE.
- OUT: POP_A → capture A; then `res_valid`=1, `res_data`=A on the cycle after CHECK, returning to IDLE.
- Underflow (`stk_error` in any POP CHECK): err, code 01, abort to IDLE; already-popped operands discarded, no restore, no result push.
- Illegal opcode: token accepted, err/code 11 in the next cycle, no stack strobe, back to IDLE.
- `tok_ready`=1 only in IDLE and not on a cycle that asserts `err` or `res_valid`.
- `stk_push` and `stk_pop` never high together; never high in consecutive cycles.

## Timing
- Reset values: `tok_ready` 0 during reset, 1 the first cycle after; `stk_push`, `stk_pop`, `res_valid`, `err` 0; `stk_data_in`, `res_data` 0x00; `err_code` 00.
- Cycle 0 = acceptance edge. Operand: strobe cycle 1, CHECK cycle 3, `tok_ready` again cycle 4 (4-cycle throughput).
- Binary op: pop strobes cycles 1 and 4, push strobe cycle 7, CHECK cycle 9, `tok_ready` cycle 10.
- OUT: strobe cycle 1, CHECK cycle 3, `res_valid` cycle 4, `tok_ready` cycle 5.
- Illegal: `err` cycle 1, `tok_ready` cycle 2.
- Errors pulse on the cycle after the failing CHECK.
- Reset mid-operation: next cycle state IDLE, all strobes low, captured operands dropped; no `err`/`res_valid` generated for the aborted token.

## Test plan
- Push 3, push 5, ADD, OUT → `res_valid` with 0x08; stack then empty (further OUT → err 01).
- Push 0x0A, push 0x03, SUB, OUT → 0x07; push 0x03, push 0x05, SUB, OUT → 0xFE; push 0xFA, push 0x0A, ADD, OUT → 0x04.
- OUT on empty stack → `err`=1, `err_code`=01 at cycle 4, no `res_valid`; push 1, ADD → err 01 at POP_B CHECK, stack empty afterwards.
- 16 operand pushes → no err; 17th → err 10; subsequent 16 OUTs return values in LIFO order.
- Opcode 111 → err 11 at cycle 1, `stk_push`/`stk_pop` never asserted, `tok_ready` at cycle 2; `tok_valid` held through busy cycles → exactly one transfer per token.
- Assert `reset` during POP_B wait of an ADD → strobes low next cycle, no err/res pulses, `tok_ready` high the cycle after reset deasserts; stack reported empty.
